// File: rtl/ingress_pkt_buffer.sv
// Store-and-forward ingress packet queue: packets become visible only once fully
// stored; packets longer than DEPTH beats are dropped and counted.
module ingress_pkt_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PKT_DEPTH  = 4,
  parameter int N_PORTS    = 4,
  parameter int IDX_WIDTH  = $clog2(N_PORTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [IDX_WIDTH-1:0]  in_dst,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [IDX_WIDTH-1:0]  out_dst,
  input  logic                  out_ready,
  output logic [7:0]            drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PKT_DEPTH);
  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);
  localparam logic [PW:0] PKT_FULL = (PW+1)'(PKT_DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] cm_ptr_q, cm_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0] pkt_cnt_q, pkt_cnt_d;
  logic [PW-1:0] dwr_ptr_q, dwr_ptr_d;
  logic [PW-1:0] drd_ptr_q, drd_ptr_d;
  logic [IDX_WIDTH-1:0] dst_q, dst_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  logic [DATA_WIDTH:0] beat_mem [DEPTH];
  logic [IDX_WIDTH-1:0] desc_mem [PKT_DEPTH];

  logic [AW:0] used, cur_len;
  logic beat_full, desc_full, rdy;
  logic beat_we, commit, pop_beat, pop_desc;
  logic [IDX_WIDTH-1:0] push_dst;
  logic [DATA_WIDTH:0] head;

  assign used      = wr_ptr_q - rd_ptr_q;
  assign cur_len   = wr_ptr_q - cm_ptr_q;
  assign beat_full = (used == FULL_LEN);
  assign desc_full = (pkt_cnt_q == PKT_FULL);

  // Head outputs are forced to zero while nothing is committed (incl. reset).
  assign out_valid  = (pkt_cnt_q != '0);
  assign head       = beat_mem[rd_ptr_q[AW-1:0]];
  assign out_data   = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign out_last   = out_valid & head[DATA_WIDTH];
  assign out_dst    = out_valid ? desc_mem[drd_ptr_q] : '0;
  assign pop_beat   = out_valid & out_ready;
  assign pop_desc   = pop_beat & head[DATA_WIDTH];
  assign in_ready   = rdy & ~reset;
  assign drop_count = drop_cnt_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    dst_d      = dst_q;
    drop_cnt_d = drop_cnt_q;
    rdy        = 1'b0;
    beat_we    = 1'b0;
    commit     = 1'b0;
    push_dst   = dst_q;
    unique case (state_q)
      IDLE: begin
        rdy = !beat_full && !desc_full;
        if (in_valid && rdy) begin
          beat_we  = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          dst_d    = in_dst;
          push_dst = in_dst;
          if (in_last) commit = 1'b1;
          else         state_d = RECV;
        end
      end
      RECV: begin
        if (cur_len == FULL_LEN) begin
          rdy = 1'b1;
          if (in_valid) begin
            wr_ptr_d = cm_ptr_q;
            if (drop_cnt_q != 8'hff)
              drop_cnt_d = drop_cnt_q + 8'd1;
            state_d = in_last ? IDLE : DROP;
          end
        end else begin
          rdy = !beat_full;
          if (in_valid && rdy) begin
            beat_we  = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (in_last) begin
              commit  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      DROP: begin
        rdy = 1'b1;
        if (in_valid && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (commit) cm_ptr_d = wr_ptr_q + 1'b1;
  end

  always_comb begin
    rd_ptr_d  = rd_ptr_q + (AW+1)'(pop_beat);
    drd_ptr_d = drd_ptr_q + PW'(pop_desc);
    dwr_ptr_d = dwr_ptr_q + PW'(commit);
    pkt_cnt_d = pkt_cnt_q;
    if (commit && !pop_desc)      pkt_cnt_d = pkt_cnt_q + 1'b1;
    else if (!commit && pop_desc) pkt_cnt_d = pkt_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      dwr_ptr_q  <= '0;
      drd_ptr_q  <= '0;
      dst_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      dwr_ptr_q  <= dwr_ptr_d;
      drd_ptr_q  <= drd_ptr_d;
      dst_q      <= dst_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_we) beat_mem[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
    if (commit)  desc_mem[dwr_ptr_q] <= push_dst;
  end

endmodule

// File: tb/tb_ingress_pkt_buffer.sv
// Bench for ingress_pkt_buffer: directed steps plus random streaming,
// checked against a packet-level queue model.
module tb_ingress_pkt_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic [1:0] in_dst;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic [1:0] out_dst;
  logic       out_ready;
  logic [7:0] drop_count;

  ingress_pkt_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_dst     (in_dst),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_dst    (out_dst),
    .out_ready  (out_ready),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int drops_m = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_e;
  logic in_pkt = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [7:0] d,
                           input logic l,
                           input logic [1:0] ds);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_dst   = ds;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [1:0] ds);
    logic [10:0] b[$];
    logic [7:0] d;
    logic l;
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom);
      l = (i == len - 1);
      send_beat(d, l, ds);
      b.push_back({ds, l, d});
    end
    if (len <= 16) begin
      foreach (b[i]) exp_q.push_back(b[i]);
    end else if (drops_m < 255) begin
      drops_m++;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0)
      check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
    check("drain_valid", out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_pkt = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", out_valid, 0);
      end else if (out_ready) begin
        mon_e = exp_q.pop_front();
        check("out_data", out_data, mon_e[7:0]);
        check("out_last", out_last, mon_e[8]);
        check("out_dst", out_dst, mon_e[10:9]);
        in_pkt = !mon_e[8];
      end
    end else if (in_pkt) begin
      check("valid_gap", out_valid, 1);
      in_pkt = 1'b0;
    end
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    in_dst = '0;
    out_ready = 1'b0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_dst", out_dst, 0);
    check("rst_drop", drop_count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 3-beat packet, visible only after the last beat
    send_beat(8'hAA, 1'b0, 2'd2);
    @(negedge clk);
    check("t1_valid_b1", out_valid, 0);
    @(posedge clk);
    #1;
    send_beat(8'hBB, 1'b0, 2'd2);
    @(negedge clk);
    check("t1_valid_b2", out_valid, 0);
    @(posedge clk);
    #1;
    send_beat(8'hCC, 1'b1, 2'd2);
    exp_q.push_back({2'd2, 1'b0, 8'hAA});
    exp_q.push_back({2'd2, 1'b0, 8'hBB});
    exp_q.push_back({2'd2, 1'b1, 8'hCC});
    @(negedge clk);
    check("t1_valid_vis", out_valid, 1);
    check("t1_dst", out_dst, 2);
    check("t1_head", out_data, 8'hAA);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // full beat FIFO stalls the next packet
    out_ready = 1'b0;
    send_pkt(16, 2'd1);
    in_valid = 1'b1;
    in_data = 8'h11;
    in_last = 1'b0;
    in_dst = 2'd0;
    @(negedge clk);
    check("t2_full_stall", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_reenable", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // oversize packet is dropped, next one intact
    send_pkt(17, 2'd3);
    @(negedge clk);
    check("t3_drop_cnt", drop_count, 1);
    check("t3_no_valid", out_valid, 0);
    @(posedge clk);
    #1;
    send_pkt(2, 2'd0);
    wait_drain();

    // descriptor FIFO limit
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_pkt(1, 2'(k));
    in_valid = 1'b1;
    in_last = 1'b1;
    in_dst = 2'd1;
    @(negedge clk);
    check("t4_desc_stall", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_pkt(1, 2'd1);
    wait_drain();

    // random streaming
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_pkt($urandom_range(1, 20), 2'($urandom_range(0, 3)));
    end
    wait_drain();
    check("t5_drop_cnt", drop_count, drops_m);

    // saturation of the drop counter
    repeat (260) send_pkt(17, 2'd0);
    @(negedge clk);
    check("sat_model", drop_count, drops_m);
    check("sat_255", drop_count, 8'hff);
    @(posedge clk);
    #1;

    // reset in the middle of a packet
    out_ready = 1'b0;
    send_beat(8'h5A, 1'b1, 2'd3);
    exp_q.push_back({2'd3, 1'b1, 8'h5A});
    @(negedge clk);
    check("t6_pre_data", out_data, 8'h5A);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) send_beat(8'(8'h30 + k), 1'b0, 2'd1);
    in_valid = 1'b1;
    in_data = 8'h77;
    in_last = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 0);
    check("t6_out_data", out_data, 0);
    check("t6_out_last", out_last, 0);
    check("t6_out_dst", out_dst, 0);
    check("t6_drop", drop_count, 0);
    in_valid = 1'b0;
    exp_q.delete();
    drops_m = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_pkt(2, 2'd2);
    wait_drain();
    check("t6_drop_after", drop_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
